// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase-cycle sequencer.
// Optional RX phase table is enabled elsewhere by PHASE_SEQ_RX_PHASE_EN.
package phase_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  // A zero-length cycle still needs one step; anything past the table depth wraps at the table end.
  function automatic int clamp_len(input int len, input int max_steps);
    if (len <= 0) return 1;
    if (len > max_steps) return max_steps;
    return len;
  endfunction

endpackage

// File: rtl/phase_table.sv
// Phase code register file: one write port, one combinational read port, async reset to 0.
// Instantiated once per phase table (TX, plus RX when PHASE_SEQ_RX_PHASE_EN is defined).
module phase_table #(
  parameter int DEPTH = 8,
  parameter int W     = 2,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/phase_cycle_sequencer.sv
// Steps through a programmable phase-cycle table once per scan, wrapping at a run-time length.
// Define PHASE_SEQ_RX_PHASE_EN to add a receiver-phase table and rx_phase output.
module phase_cycle_sequencer
  import phase_seq_pkg::*;
#(
  parameter int PHASE_W   = 2,
  parameter int MAX_STEPS = 8,
  localparam int AW       = $clog2(MAX_STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PHASE_W-1:0] wr_data,
  input  logic [AW:0]        cycle_len,
  input  logic               start,
  input  logic               advance,
  input  logic               stop,
  output logic [PHASE_W-1:0] active_phase,
  output logic [AW-1:0]      step_idx,
  output logic               running,
  output logic               cycle_done,
  output logic               wr_err
`ifdef PHASE_SEQ_RX_PHASE_EN
  ,
  input  logic [PHASE_W-1:0] wr_rx_data,
  output logic [PHASE_W-1:0] rx_phase
`endif
);

  state_e             state_reg, state_next;
  logic [AW:0]        len_reg, len_next;
  logic [AW-1:0]      step_reg, step_next;
  logic [PHASE_W-1:0] phase_reg, phase_next, tx_rd;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               addr_ok, tbl_we, last_step;

  assign addr_ok   = ({1'b0, wr_addr} < (AW+1)'(MAX_STEPS));
  assign tbl_we    = wr_en && (state_reg == ST_IDLE) && addr_ok;
  assign last_step = ({1'b0, step_reg} == (len_reg - (AW+1)'(1)));

  phase_table #(.DEPTH(MAX_STEPS), .W(PHASE_W), .AW(AW)) u_tx_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (step_next),
    .rdata (tx_rd)
  );

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    step_next  = step_reg;
    done_next  = 1'b0;
    err_next   = wr_en && ((state_reg == ST_RUN) || !addr_ok);
    case (state_reg)
      ST_IDLE: begin
        // start wins over a coincident advance, which is simply not looked at here
        if (start) begin
          state_next = ST_RUN;
          len_next   = (AW+1)'(clamp_len(int'(cycle_len), MAX_STEPS));
          step_next  = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
          step_next  = '0;
        end else if (advance) begin
          if (last_step) begin
            step_next = '0;
            done_next = 1'b1;
          end else begin
            step_next = step_reg + AW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Phase is looked up at the next step index so it lands in the same cycle as step_idx.
  assign phase_next = (state_next == ST_RUN) ? tx_rd : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      step_reg  <= '0;
      phase_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      step_reg  <= step_next;
      phase_reg <= phase_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign active_phase = phase_reg;
  assign step_idx     = step_reg;
  assign running      = (state_reg == ST_RUN);
  assign cycle_done   = done_reg;
  assign wr_err       = err_reg;

`ifdef PHASE_SEQ_RX_PHASE_EN
  logic [PHASE_W-1:0] rx_rd, rx_phase_reg;

  phase_table #(.DEPTH(MAX_STEPS), .W(PHASE_W), .AW(AW)) u_rx_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (wr_addr),
    .wdata (wr_rx_data),
    .raddr (step_next),
    .rdata (rx_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_phase_reg <= '0;
    else     rx_phase_reg <= (state_next == ST_RUN) ? rx_rd : '0;
  end

  assign rx_phase = rx_phase_reg;
`endif

endmodule

// File: tb/tb_phase_cycle_sequencer.sv
// Scoreboard bench for phase_cycle_sequencer: directed scenarios then random traffic.
// Covers the RX table too when compiled with PHASE_SEQ_RX_PHASE_EN.
module tb_phase_cycle_sequencer;

  localparam int PHASE_W   = 2;
  localparam int MAX_STEPS = 8;
  localparam int AW        = 3;

  logic               clk = 1'b0;
  logic               rst, wr_en, start, advance, stop;
  logic [AW-1:0]      wr_addr;
  logic [PHASE_W-1:0] wr_data, wr_rx_data;
  logic [AW:0]        cycle_len;
  logic [PHASE_W-1:0] active_phase, rx_phase;
  logic [AW-1:0]      step_idx;
  logic               running, cycle_done, wr_err;

  phase_cycle_sequencer #(.PHASE_W(PHASE_W), .MAX_STEPS(MAX_STEPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cycle_len    (cycle_len),
    .start        (start),
    .advance      (advance),
    .stop         (stop),
    .active_phase (active_phase),
    .step_idx     (step_idx),
    .running      (running),
    .cycle_done   (cycle_done),
    .wr_err       (wr_err)
`ifdef PHASE_SEQ_RX_PHASE_EN
    ,
    .wr_rx_data   (wr_rx_data),
    .rx_phase     (rx_phase)
`endif
  );

`ifndef PHASE_SEQ_RX_PHASE_EN
  assign rx_phase = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int idx;
    bit run;
    bit done;
    bit err;
    int rx;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a run flag, a step counter and plain integer tables.
  bit m_run;
  int m_idx, m_len;
  int m_tbl[MAX_STEPS];
  int m_rx_tbl[MAX_STEPS];

  task automatic model_edge();
    exp_t e;
    bit   do_wr;
    int   cl;
    e = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
    if (rst) begin
      m_run = 1'b0;
      m_idx = 0;
      m_len = 0;
      for (int i = 0; i < MAX_STEPS; i++) begin
        m_tbl[i]    = 0;
        m_rx_tbl[i] = 0;
      end
    end else begin
      do_wr = wr_en && !m_run && (int'(wr_addr) < MAX_STEPS);
      e.err = wr_en && !do_wr;
      if (!m_run) begin
        if (start) begin
          cl    = int'(cycle_len);
          m_run = 1'b1;
          m_len = (cl == 0) ? 1 : ((cl > MAX_STEPS) ? MAX_STEPS : cl);
          m_idx = 0;
        end
      end else if (stop) begin
        m_run = 1'b0;
        m_idx = 0;
      end else if (advance) begin
        m_idx = m_idx + 1;
        if (m_idx >= m_len) begin
          m_idx  = 0;
          e.done = 1'b1;
        end
      end
      e.run   = m_run;
      e.idx   = m_idx;
      e.phase = m_run ? m_tbl[m_idx] : 0;
`ifdef PHASE_SEQ_RX_PHASE_EN
      e.rx    = m_run ? m_rx_tbl[m_idx] : 0;
`endif
      if (do_wr) begin
        m_tbl[wr_addr]    = int'(wr_data);
        m_rx_tbl[wr_addr] = int'(wr_rx_data);
      end
    end
    sb_q.push_back(e);
  endtask

  // Monitor: every clock the DUT presents a new output set; compare it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (int'(active_phase) != e.phase || int'(step_idx) != e.idx || running != e.run ||
            cycle_done != e.done || wr_err != e.err || int'(rx_phase) != e.rx) begin
          n_fail++;
          $display("FAIL outputs txn %0d t=%0t: got phase=%0d idx=%0d run=%0b done=%0b err=%0b rx=%0d, expected phase=%0d idx=%0d run=%0b done=%0b err=%0b rx=%0d",
                   n_checks, $time, active_phase, step_idx, running, cycle_done, wr_err, rx_phase,
                   e.phase, e.idx, e.run, e.done, e.err, e.rx);
        end else begin
          $display("txn %0d: phase=%0d idx=%0d run=%0b done=%0b err=%0b rx=%0d ok",
                   n_checks, active_phase, step_idx, running, cycle_done, wr_err, rx_phase);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    wr_en   = 1'b0;
    start   = 1'b0;
    advance = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic wr(input int addr, input int data, input int rxdata);
    wr_en      = 1'b1;
    wr_addr    = AW'(addr);
    wr_data    = PHASE_W'(data);
    wr_rx_data = PHASE_W'(rxdata);
    tick();
  endtask

  task automatic do_start(input int len);
    cycle_len = (AW+1)'(len);
    start     = 1'b1;
    tick();
  endtask

  task automatic do_advance();
    advance = 1'b1;
    tick();
  endtask

  // Reset is asynchronous: outputs must clear before any clock edge arrives.
  task automatic async_reset_check();
    rst = 1'b1;
    #1;
    n_checks++;
    if (active_phase != '0 || step_idx != '0 || running || cycle_done || wr_err || rx_phase != '0) begin
      n_fail++;
      $display("FAIL async_reset: got phase=%0d idx=%0d run=%0b done=%0b err=%0b, expected all 0",
               active_phase, step_idx, running, cycle_done, wr_err);
    end else begin
      $display("txn async_reset: outputs cleared ok");
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; advance = 1'b0; stop = 1'b0;
    wr_addr = '0; wr_data = '0; wr_rx_data = '0; cycle_len = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Wrap: table {1,2,3,0}, RX table {0,2,1,3}, length 4, eight advances
    wr(0, 1, 0); wr(1, 2, 2); wr(2, 3, 1); wr(3, 0, 3);
    do_start(4);
    for (int i = 0; i < 8; i++) begin
      do_advance();
      tick();
    end

    // Writes while running are rejected and leave the table alone
    wr(2, 0, 0);
    wr(2, 3, 3);
    stop = 1'b1; tick();
    do_start(4);
    do_advance(); do_advance();
    tick();

    // stop + advance on the last step, then start + advance in IDLE
    do_advance();
    stop = 1'b1; advance = 1'b1; tick();
    tick();
    advance = 1'b1; tick();
    start = 1'b1; advance = 1'b1; cycle_len = 4; tick();
    start = 1'b1; tick();
    do_advance();

    // Clamp low: zero length wraps on every advance; length changes mid-run are ignored
    stop = 1'b1; tick();
    do_start(0);
    cycle_len = 5;
    for (int i = 0; i < 3; i++) do_advance();
    stop = 1'b1; tick();

    // Clamp high: 15 behaves as MAX_STEPS
    for (int i = 4; i < MAX_STEPS; i++) wr(i, i % 4, (i + 1) % 4);
    do_start(15);
    for (int i = 0; i < 10; i++) do_advance();

    // Asynchronous reset mid-run, then restart from a cleared table
    async_reset_check();
    do_start(3);
    do_advance();
    stop = 1'b1; tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset_check();
      end else begin
        wr_en      = ($urandom_range(0, 99) < 20);
        wr_addr    = AW'($urandom_range(0, MAX_STEPS - 1));
        wr_data    = PHASE_W'($urandom_range(0, 3));
        wr_rx_data = PHASE_W'($urandom_range(0, 3));
        cycle_len  = (AW+1)'($urandom_range(0, 15));
        start      = ($urandom_range(0, 99) < 10);
        advance    = ($urandom_range(0, 99) < 45);
        stop       = ($urandom_range(0, 99) < 4);
        tick();
      end
    end

    tick();
    tick();
    #2;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
